// File: rtl/fetch_prefetch_q_if.sv
// fetch_prefetch_q_if: bundles the two handshakes of the fetch unit.
//   imem side : imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in
//   DEC side  : if_valid/instr_dec/pc_dec out, dec_ready in
// master = fetch unit, slave = environment (imem_ctrl + DEC).
interface fetch_prefetch_q_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] instr_dec;
  logic [ADDR_WIDTH-1:0]  pc_dec;
  logic                   dec_ready;

  modport master (
    output imem_req, imem_addr, if_valid, instr_dec, pc_dec,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, instr_dec, pc_dec,
    output imem_gnt, imem_rvalid, imem_rdata, dec_ready
  );
endinterface

// File: rtl/fetch_prefetch_q.sv
// fetch_prefetch_q: sequential instruction fetch with up to MAX_OUTST requests
// in flight and a DEPTH-entry prefetch queue feeding DEC.
// Ports:
//   cpu_clk, cpu_rstn         clock, async active-low reset
//   i_boot_addr               first fetch address after reset
//   i_trap/i_vector_addr      redirect, highest priority
//   i_mret/i_mepc             redirect, second priority
//   i_redirect/i_redirect_addr EX branch/jump redirect, lowest priority
//   io_bus                    imem request/response and DEC handshakes
//   o_pc_misaligned           one-cycle pulse after a misaligned redirect
//   o_fault_pc                misaligned target, held until the next redirect
module fetch_prefetch_q #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int MAX_OUTST   = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [ADDR_WIDTH-1:0] i_boot_addr,
  input  logic                  i_trap,
  input  logic [ADDR_WIDTH-1:0] i_vector_addr,
  input  logic                  i_mret,
  input  logic [ADDR_WIDTH-1:0] i_mepc,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  fetch_prefetch_q_if.master    io_bus,
  output logic                  o_pc_misaligned,
  output logic [ADDR_WIDTH-1:0] o_fault_pc
);
  localparam int QW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int SW = QW + 2;
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTST);
  localparam logic [QW:0]   FULL = (QW+1)'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0]                  r_fpc;
  logic [QW:0]                            r_count;
  logic [QW-1:0]                          r_head, r_tail;
  logic [OW-1:0]                          r_outst, r_drop;
  logic [DEPTH-1:0][INSTR_WIDTH-1:0]      r_q_instr;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]       r_q_pc;
  logic [MAX_OUTST-1:0][ADDR_WIDTH-1:0]   r_af_pc;
  logic [FW-1:0]                          r_af_wr, r_af_rd;
  logic                                   r_mis;
  logic [ADDR_WIDTH-1:0]                  r_fault;

  logic                  w_flush, w_tgt_mis, w_room, w_req, w_grant, w_rsp, w_push, w_pop;
  logic [ADDR_WIDTH-1:0] w_target;

  function automatic logic [FW-1:0] af_nxt(input logic [FW-1:0] p);
    return (p == FW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_flush   = i_trap | i_mret | i_redirect;
  assign w_target  = i_trap ? i_vector_addr : (i_mret ? i_mepc : i_redirect_addr);
  assign w_tgt_mis = |w_target[1:0];
  // Credit rule: a request is only issued if its response already owns a slot.
  assign w_room    = (r_outst < MAXO) && ((SW'(r_count) + SW'(r_outst)) < SW'(DEPTH));
  assign w_rsp     = io_bus.imem_rvalid;
  assign w_grant   = w_req & io_bus.imem_gnt;
  assign w_push    = w_rsp & ~w_flush & (r_drop == '0);
  assign w_pop     = (r_count != '0) & io_bus.dec_ready & ~w_flush;

  // FSM: next state and request output
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    if (w_flush) begin
      if (w_tgt_mis)                                  w_state_nxt = S_FAULT;
      else if (r_state != S_FAULT || i_trap || i_mret) w_state_nxt = S_RUN;
    end else begin
      if (r_state == S_BOOT) w_state_nxt = S_RUN;
      if (r_state == S_RUN)  w_req = w_room;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) r_state <= S_BOOT;
    else           r_state <= w_state_nxt;

  // fetch PC, in-flight accounting, fault reporting
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_fpc   <= i_boot_addr;
      r_outst <= '0;
      r_drop  <= '0;
      r_mis   <= 1'b0;
      r_fault <= '0;
    end else begin
      if (w_flush)      r_fpc <= w_target;
      else if (w_grant) r_fpc <= r_fpc + ADDR_WIDTH'(4);
      if (w_grant & ~w_rsp)      r_outst <= r_outst + 1'b1;
      else if (~w_grant & w_rsp) r_outst <= r_outst - 1'b1;
      // everything still in flight after this cycle belongs to the old stream
      if (w_flush)                   r_drop <= r_outst - OW'(w_rsp);
      else if (w_rsp && r_drop != '0) r_drop <= r_drop - 1'b1;
      r_mis <= w_flush & w_tgt_mis;
      if (w_flush) r_fault <= w_tgt_mis ? w_target : '0;
    end
  end

  // request-PC FIFO: every response, dropped or not, retires one entry
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_af_wr <= '0;
      r_af_rd <= '0;
    end else begin
      if (w_grant) r_af_wr <= af_nxt(r_af_wr);
      if (w_rsp)   r_af_rd <= af_nxt(r_af_rd);
    end
  end

  always_ff @(posedge cpu_clk)
    if (w_grant) r_af_pc[r_af_wr] <= r_fpc;

  // prefetch queue
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_count   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_q_instr <= '0;
      r_q_pc    <= {DEPTH{i_boot_addr}};
    end else if (w_flush) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_tail] <= io_bus.imem_rdata;
        r_q_pc[r_tail]    <= r_af_pc[r_af_rd];
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end
  end

  assign io_bus.imem_req   = w_req;
  assign io_bus.imem_addr  = r_fpc;
  assign io_bus.if_valid   = (r_count != '0);
  assign io_bus.instr_dec  = r_q_instr[r_head];
  assign io_bus.pc_dec     = r_q_pc[r_head];
  assign o_pc_misaligned   = r_mis;
  assign o_fault_pc        = r_fault;

  a_rsp_outst: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    io_bus.imem_rvalid |-> (r_outst != '0));
  a_no_ovf: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    w_push |-> (r_count != FULL));
endmodule

// File: tb/tb_fetch_prefetch_q.sv
`timescale 1ns/1ps
module tb_fetch_prefetch_q;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] boot_addr, vector_addr, mepc, redirect_addr, fault_pc;
  logic        trap, mret, redirect, pc_mis;

  fetch_prefetch_q_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_prefetch_q #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .i_boot_addr(boot_addr),
    .i_trap(trap), .i_vector_addr(vector_addr), .i_mret(mret), .i_mepc(mepc),
    .i_redirect(redirect), .i_redirect_addr(redirect_addr), .io_bus(bus),
    .o_pc_misaligned(pc_mis), .o_fault_pc(fault_pc)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct { logic dr, tr, mr, rd; logic [31:0] va, ma, ra; } in_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; int due; } rq_t;
  typedef struct { logic dr; logic req; logic [31:0] addr; logic ifv; logic [31:0] pc; } vec_t;

  int n_chk = 0, n_err = 0, cyc = 0;
  int lat_mode = 1;      // 0 = random 1..3 cycles
  bit gnt_rand = 0;

  // reference model: queue contents, in-flight requests, fetch pointer, mode
  logic [31:0] m_q[$];
  fl_t         m_out[$];
  rq_t         imq[$];   // imem environment: pending responses
  logic [31:0] m_fpc, m_fault;
  bit          m_mis;
  int          m_mode;   // 0 boot, 1 run, 2 fault

  logic        s_req, s_ifv, s_mis;
  logic [31:0] s_addr, s_pc, s_instr, s_fault;

  function automatic logic [31:0] f_ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  function automatic in_t mk(input logic dr);
    in_t s;
    s.dr = dr; s.tr = 1'b0; s.mr = 1'b0; s.rd = 1'b0;
    s.va = '0; s.ma = '0; s.ra = '0;
    return s;
  endfunction

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] ba);
    @(negedge cpu_clk);
    boot_addr = ba; trap = 0; mret = 0; redirect = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dec_ready = 0;
    #2 cpu_rstn = 1'b0;
    #1;
    chk("rst if_valid",      bus.if_valid, 0);
    chk("rst imem_req",      bus.imem_req, 0);
    chk("rst imem_addr",     bus.imem_addr, ba);
    chk("rst pc_dec",        bus.pc_dec, ba);
    chk("rst instr_dec",     bus.instr_dec, 0);
    chk("rst pc_misaligned", pc_mis, 0);
    chk("rst fault_pc",      fault_pc, 0);
    m_q.delete(); m_out.delete(); imq.delete();
    m_fpc = ba; m_mode = 0; m_mis = 0; m_fault = '0;
    repeat (2) @(posedge cpu_clk);
    #2 cpu_rstn = 1'b1;
  endtask

  // One clock cycle: drive at negedge, sample and check against the model,
  // then advance the model and the imem environment at the posedge.
  task automatic step(input in_t s);
    logic flush, e_req, gnt, rv, mg, pop;
    logic [31:0] tgt;
    fl_t o;
    int lat;
    @(negedge cpu_clk);
    bus.dec_ready = s.dr; trap = s.tr; mret = s.mr; redirect = s.rd;
    vector_addr = s.va; mepc = s.ma; redirect_addr = s.ra;
    gnt = gnt_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    bus.imem_gnt = gnt;
    rv = (imq.size() != 0) && (imq[0].due <= cyc);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? f_ins(imq[0].addr) : $urandom();
    #1;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_ifv = bus.if_valid;
    s_pc = bus.pc_dec; s_instr = bus.instr_dec; s_mis = pc_mis; s_fault = fault_pc;
    flush = s.tr | s.mr | s.rd;
    e_req = (m_mode == 1) && !flush && (m_out.size() < MAXO) && (m_q.size() + m_out.size() < DEPTH);
    chk("imem_req",  s_req, e_req);
    chk("imem_addr", s_addr, m_fpc);
    chk("if_valid",  s_ifv, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("pc_dec",    s_pc, m_q[0]);
      chk("instr_dec", s_instr, f_ins(m_q[0]));
    end
    chk("pc_misaligned", s_mis, m_mis);
    chk("fault_pc",      s_fault, m_fault);
    mg  = e_req & gnt;
    pop = (m_q.size() != 0) & s.dr & !flush;
    @(posedge cpu_clk);
    if (rv) void'(imq.pop_front());
    if (s_req & gnt) begin
      lat = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      imq.push_back('{s_addr, cyc + lat});
    end
    if (flush) begin
      tgt = s.tr ? s.va : (s.mr ? s.ma : s.ra);
      if (rv && m_out.size() != 0) void'(m_out.pop_front());
      foreach (m_out[k]) m_out[k].stale = 1'b1;
      m_q.delete();
      m_fpc = tgt;
      m_mis = (tgt[1:0] != 2'b00);
      m_fault = m_mis ? tgt : '0;
      if (m_mis) m_mode = 2;
      else if (m_mode != 2 || s.tr || s.mr) m_mode = 1;
    end else begin
      m_mis = 0;
      if (m_mode == 0) m_mode = 1;
      if (pop) void'(m_q.pop_front());
      if (rv && m_out.size() != 0) begin
        o = m_out.pop_front();
        if (!o.stale) m_q.push_back(o.pc);
      end
      if (mg) begin
        m_out.push_back('{m_fpc, 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    in_t  s;
    bit   found;
    int   r;
    boot_addr = 32'h100; trap = 0; mret = 0; redirect = 0;
    vector_addr = '0; mepc = '0; redirect_addr = '0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.dec_ready = 0;

    // boot stream with DEC stalled for 10 cycles, 1-cycle imem
    tbl[0]  = '{0, 0, 32'h100, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h100, 0, 32'h0};
    tbl[2]  = '{0, 1, 32'h104, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'h108, 1, 32'h100};
    tbl[4]  = '{0, 1, 32'h10C, 1, 32'h100};
    tbl[5]  = '{0, 0, 32'h110, 1, 32'h100};
    tbl[6]  = '{0, 0, 32'h110, 1, 32'h100};
    tbl[7]  = '{0, 0, 32'h110, 1, 32'h100};
    tbl[8]  = '{0, 0, 32'h110, 1, 32'h100};
    tbl[9]  = '{0, 0, 32'h110, 1, 32'h100};
    tbl[10] = '{1, 0, 32'h110, 1, 32'h100};
    tbl[11] = '{1, 1, 32'h110, 1, 32'h104};
    tbl[12] = '{1, 1, 32'h114, 1, 32'h108};
    tbl[13] = '{1, 1, 32'h118, 1, 32'h10C};
    tbl[14] = '{1, 1, 32'h11C, 1, 32'h110};
    tbl[15] = '{1, 1, 32'h120, 1, 32'h114};

    do_reset(32'h100);
    for (int i = 0; i < 16; i++) begin
      step(mk(tbl[i].dr));
      chk($sformatf("tbl%0d imem_req", i),  s_req,  tbl[i].req);
      chk($sformatf("tbl%0d imem_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d if_valid", i),  s_ifv,  tbl[i].ifv);
      if (tbl[i].ifv) chk($sformatf("tbl%0d pc_dec", i), s_pc, tbl[i].pc);
    end

    // redirect with two requests in flight, 3-cycle imem
    do_reset(32'h100); lat_mode = 3;
    repeat (7) step(mk(0));
    s = mk(0); s.rd = 1; s.ra = 32'h200; step(s);
    step(mk(1)); chk("redir flushed if_valid", s_ifv, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(mk(1));
      if (s_ifv) found = 1;
    end
    chk("redir ifv seen", found, 1);
    chk("redir first pc", s_pc, 32'h200);

    // priority trap > mret > redirect
    do_reset(32'h100); lat_mode = 1;
    repeat (6) step(mk(1));
    s = mk(1); s.tr = 1; s.mr = 1; s.rd = 1; s.va = 32'h40; s.ma = 32'h80; s.ra = 32'h300; step(s);
    step(mk(1)); chk("prio req t+1", s_req, 1); chk("prio addr t+1", s_addr, 32'h40);
    step(mk(1)); step(mk(1));
    chk("prio ifv t+3", s_ifv, 1); chk("prio pc t+3", s_pc, 32'h40);
    s = mk(1); s.mr = 1; s.rd = 1; s.ma = 32'h80; s.ra = 32'h300; step(s);
    step(mk(1)); chk("mret over redirect", s_addr, 32'h80);

    // misaligned target, then recovery by trap
    s = mk(1); s.rd = 1; s.ra = 32'h202; step(s);
    step(mk(1));
    chk("mis pulse", s_mis, 1); chk("mis fault_pc", s_fault, 32'h202); chk("mis req", s_req, 0);
    step(mk(1));
    chk("mis pulse end", s_mis, 0); chk("mis req low", s_req, 0); chk("mis fault held", s_fault, 32'h202);
    s = mk(1); s.rd = 1; s.ra = 32'h300; step(s);
    step(mk(1)); chk("fault kept on redirect", s_req, 0);
    s = mk(1); s.tr = 1; s.va = 32'h40; step(s);
    step(mk(1));
    chk("trap resume req", s_req, 1); chk("trap resume addr", s_addr, 32'h40);
    chk("trap fault_pc clr", s_fault, 0);

    // address wrap, then reset mid-stream with a different boot address
    s = mk(1); s.rd = 1; s.ra = 32'hFFFF_FFFC; step(s);
    step(mk(1)); chk("wrap req", s_req, 1); chk("wrap addr top", s_addr, 32'hFFFF_FFFC);
    step(mk(1)); chk("wrap addr zero", s_addr, 32'h0);
    repeat (3) step(mk(0));
    do_reset(32'h400);
    repeat (4) step(mk(1));
    chk("reboot ifv cycle3", s_ifv, 1); chk("reboot pc cycle3", s_pc, 32'h400);

    // randomized traffic against the reference model
    gnt_rand = 1; lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      s = mk($urandom_range(0, 3) != 0);
      s.va = rnd_tgt(); s.ma = rnd_tgt(); s.ra = rnd_tgt();
      if (r < 3)       s.rd = 1;
      else if (r < 5)  s.tr = 1;
      else if (r < 7)  s.mr = 1;
      else if (r == 7) begin s.tr = 1; s.mr = 1; s.rd = 1; end
      if (i == 1500) do_reset(32'h0000_0800);
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_q.md
Name: fetch_prefetch_q

Overview:
- Parametrised next-generation instruction fetch unit for the krv core.
- Issues sequential requests to imem_ctrl through a valid/grant handshake and keeps up to MAX_OUTST requests in flight.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue; the queue feeds DEC through a valid/ready handshake.
- On a redirect (trap, mret, branch/jal/jalr), flushes the queue and drops stale in-flight responses.

Parameters:
ADDR_WIDTH, 32, PC/imem address width
INSTR_WIDTH, 32, instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUTST, 2, maximum outstanding imem requests (1..DEPTH)

Ports:
cpu_clk  in  1  cpu clock
cpu_rstn  in  1  asynchronous active-low reset
boot_addr  in  ADDR_WIDTH  first fetch address after reset
trap  in  1  trap redirect, highest priority
vector_addr  in  ADDR_WIDTH  trap target
mret  in  1  return redirect, priority 2
mepc  in  ADDR_WIDTH  mret target
redirect  in  1  branch/jal/jalr taken at EX, priority 3
redirect_addr  in  ADDR_WIDTH  EX-computed target
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_WIDTH  fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  in-order response valid
imem_rdata  in  INSTR_WIDTH  response instruction
if_valid  out  1  queue head valid to DEC
instr_dec  out  INSTR_WIDTH  head instruction
pc_dec  out  ADDR_WIDTH  head PC
dec_ready  in  1  DEC pops head when if_valid & dec_ready
pc_misaligned  out  1  one-cycle pulse, misaligned redirect target
fault_pc  out  ADDR_WIDTH  held misaligned target, else 0

Behaviour:
- Reset values: imem_req=0, imem_addr=boot_addr, if_valid=0, instr_dec=0, pc_dec=boot_addr, pc_misaligned=0, fault_pc=0; queue empty; outst=0; drop=0; FSM=BOOT.
- FSM:
  - BOOT: lasts one cycle, then RUN.
  - RUN: issue requests.
  - FAULT: no requests. Left only on the next trap or mret whose target is aligned. trap/mret/redirect to a misaligned target re-enters FAULT.
- Fetch PC register fpc: loads boot_addr at reset and advances by 4 on each grant (imem_req & imem_gnt), wrapping modulo 2^ADDR_WIDTH. imem_addr=fpc.
- Issue rule: imem_req = RUN & !flush & (outst < MAX_OUTST) & (count + outst < DEPTH). This credit rule guarantees every response has a free slot. imem_req may drop without a grant.
- outst: +1 on grant, -1 on imem_rvalid; both in one cycle leaves it unchanged. imem_rvalid with outst=0 is illegal (assertion).
- flush = trap | mret | redirect. Target selected by priority trap > mret > redirect.
- Same cycle as flush:
  - queue cleared (count=0, pointers reset);
  - fpc <= target;
  - drop <= outst minus (1 if imem_rvalid this cycle);
  - imem_req=0 that cycle.
  - A pop or a response in that cycle is discarded.
- Response handling:
  - While drop>0, each imem_rvalid decrements drop and is not written.
  - Otherwise imem_rvalid writes {imem_rdata, pc of that request} at tail. Each request's pc is kept in a MAX_OUTST-entry address FIFO.
- Output: if_valid = count!=0; instr_dec/pc_dec = head entry, driven from storage with no combinational path from imem_rdata.
- Latency: redirect at cycle t gives imem_req high at t+1 with imem_addr=target. With a 1-cycle imem, the instruction is presented to DEC at t+3.
- Simultaneous push and pop at full or empty: allowed; count unchanged. With the credit rule, a push into a full queue never occurs (assertion).
- Misaligned target (target[1:0]!=0):
  - pc_misaligned pulses the cycle after flush;
  - fault_pc holds target until the next flush;
  - FSM enters FAULT.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Responses in flight are the SoC's responsibility; imem_ctrl is reset by the same cpu_rstn.

Test Plan:
- Boot stream: boot_addr=0x100, 1-cycle imem, dec_ready=1 -> grants at 0x100,0x104,0x108…; if_valid first high cycle 3 with pc_dec=0x100, then one instruction per cycle.
- Backpressure: dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued, imem_req low once count+outst=4; resuming pops 0x100..0x10C in order with no loss.
- Redirect with 2 outstanding (imem latency 3): redirect_addr=0x200 -> queue flushed, the next 2 responses dropped, first if_valid has pc_dec=0x200.
- Priority: trap, mret and redirect asserted together, vector_addr=0x40, mepc=0x80 -> next imem_addr=0x40.
- Misaligned: redirect_addr=0x202 -> pc_misaligned one pulse, fault_pc=0x202, imem_req stays 0; then trap with vector_addr=0x40 -> fetch resumes at 0x40, fault_pc=0.
- Wrap and reset: fpc=0xFFFFFFFC grant -> next imem_addr=0x0; assert cpu_rstn low mid-stream -> if_valid=0, imem_addr=boot_addr immediately.
